// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared ANN select encodings, layer sizes and loader state type
package ann_pkg;

    localparam int IMAGE_SIZE   = 64;
    localparam int FIRST_LAYER  = 16;
    localparam int SECOND_LAYER = 8;
    localparam int THIRD_LAYER  = 10;

    localparam int DATA_WIDTH   = 16;
    localparam int ADDR_WIDTH   = 16;
    localparam int CNT_WIDTH    = 11;

    localparam logic [15:0] IMAGE_BASE = 16'h0000;
    localparam logic [15:0] W1_BASE    = 16'h0040;
    localparam logic [15:0] W2_BASE    = 16'h0440;
    localparam logic [15:0] W3_BASE    = 16'h04C0;

    localparam logic [1:0] SEL_W1    = 2'b00;
    localparam logic [1:0] SEL_W2    = 2'b01;
    localparam logic [1:0] SEL_W3    = 2'b10;
    localparam logic [1:0] SEL_IMAGE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        WRITE,
        DONE
    } loader_state_t;

endpackage

// File: rtl/ann_block_lut.sv
// rtl/ann_block_lut.sv - maps a coefficient block select to its SRAM base and word count
//
// Ports:
//   i_sel   - block select (SEL_W1/SEL_W2/SEL_W3/SEL_IMAGE)
//   o_base  - SRAM word address of the first word of the block
//   o_count - number of words in the block
module ann_block_lut
    import ann_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ann_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] IMAGE_BASE = ADDR_WIDTH'(ann_pkg::IMAGE_BASE),
    parameter logic [ADDR_WIDTH-1:0] W1_BASE    = ADDR_WIDTH'(ann_pkg::W1_BASE),
    parameter logic [ADDR_WIDTH-1:0] W2_BASE    = ADDR_WIDTH'(ann_pkg::W2_BASE),
    parameter logic [ADDR_WIDTH-1:0] W3_BASE    = ADDR_WIDTH'(ann_pkg::W3_BASE)
) (
    input  logic [1:0]            i_sel,
    output logic [ADDR_WIDTH-1:0] o_base,
    output logic [CNT_WIDTH-1:0]  o_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_W1    = CNT_WIDTH'(IMAGE_SIZE * FIRST_LAYER);
    localparam logic [CNT_WIDTH-1:0] CNT_W2    = CNT_WIDTH'(FIRST_LAYER * SECOND_LAYER);
    localparam logic [CNT_WIDTH-1:0] CNT_W3    = CNT_WIDTH'(SECOND_LAYER * THIRD_LAYER);
    localparam logic [CNT_WIDTH-1:0] CNT_IMAGE = CNT_WIDTH'(IMAGE_SIZE);

    always_comb begin
        o_base  = IMAGE_BASE;
        o_count = CNT_IMAGE;
        case (i_sel)
            SEL_W1: begin
                o_base  = W1_BASE;
                o_count = CNT_W1;
            end
            SEL_W2: begin
                o_base  = W2_BASE;
                o_count = CNT_W2;
            end
            SEL_W3: begin
                o_base  = W3_BASE;
                o_count = CNT_W3;
            end
            default: begin
                o_base  = IMAGE_BASE;
                o_count = CNT_IMAGE;
            end
        endcase
    end

endmodule

// File: rtl/ann_coef_loader.sv
// rtl/ann_coef_loader.sv - copies one selected coefficient/image block from SRAM into the ANN buffer
//
// Ports:
//   clk, n_rst            - clock, asynchronous active-low reset
//   request_coef          - one-cycle load request (accepted only in IDLE)
//   coef_select           - block select, latched on an accepted request
//   sram_read_en          - one-cycle read strobe per word
//   sram_addr             - SRAM word address, held until the data returns
//   sram_rdata/rvalid     - SRAM read return (rvalid honoured only while waiting)
//   coef_wr_en            - buffer write strobe
//   coef_addr/coef_data   - buffer index and word
//   coef_dest             - latched select qualifying coef_wr_en
//   image_weights_loaded  - one-cycle completion pulse
//   busy                  - high whenever a transfer is in progress
module ann_coef_loader
    import ann_pkg::*;
#(
    parameter int                    DATA_WIDTH = ann_pkg::DATA_WIDTH,
    parameter int                    ADDR_WIDTH = ann_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] IMAGE_BASE = ADDR_WIDTH'(ann_pkg::IMAGE_BASE),
    parameter logic [ADDR_WIDTH-1:0] W1_BASE    = ADDR_WIDTH'(ann_pkg::W1_BASE),
    parameter logic [ADDR_WIDTH-1:0] W2_BASE    = ADDR_WIDTH'(ann_pkg::W2_BASE),
    parameter logic [ADDR_WIDTH-1:0] W3_BASE    = ADDR_WIDTH'(ann_pkg::W3_BASE)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  request_coef,
    input  logic [1:0]            coef_select,
    output logic                  sram_read_en,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    input  logic                  sram_rvalid,
    output logic                  coef_wr_en,
    output logic [10:0]           coef_addr,
    output logic [DATA_WIDTH-1:0] coef_data,
    output logic [1:0]            coef_dest,
    output logic                  image_weights_loaded,
    output logic                  busy
);

    loader_state_t r_state;
    loader_state_t w_state_next;

    logic [1:0]            r_sel;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [DATA_WIDTH-1:0] r_data;

    logic [ADDR_WIDTH-1:0] w_base;
    logic [CNT_WIDTH-1:0]  w_count;
    logic                  w_last;

    // Driven from the latched select so the block geometry cannot change mid-transfer.
    ann_block_lut #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .IMAGE_BASE (IMAGE_BASE),
        .W1_BASE    (W1_BASE),
        .W2_BASE    (W2_BASE),
        .W3_BASE    (W3_BASE)
    ) u_lut (
        .i_sel   (r_sel),
        .o_base  (w_base),
        .o_count (w_count)
    );

    assign w_last = (r_cnt == (w_count - CNT_WIDTH'(1)));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (request_coef) w_state_next = ISSUE;
            ISSUE:     w_state_next = WAIT_DATA;
            WAIT_DATA: if (sram_rvalid) w_state_next = WRITE;
            WRITE:     w_state_next = w_last ? DONE : ISSUE;
            DONE:      w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sel  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (request_coef) begin
                        r_sel <= coef_select;
                        r_cnt <= '0;
                    end
                end
                WAIT_DATA: begin
                    if (sram_rvalid) r_data <= sram_rdata;
                end
                WRITE: begin
                    // The counter stops on the last index so coef_addr never wraps.
                    if (!w_last) r_cnt <= r_cnt + CNT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign sram_read_en         = (r_state == ISSUE);
    assign sram_addr            = ((r_state == ISSUE) || (r_state == WAIT_DATA))
                                  ? (w_base + ADDR_WIDTH'(r_cnt)) : '0;
    assign coef_wr_en           = (r_state == WRITE);
    assign coef_addr            = r_cnt;
    assign coef_data            = r_data;
    assign coef_dest            = r_sel;
    assign image_weights_loaded = (r_state == DONE);
    assign busy                 = (r_state != IDLE);

endmodule

// File: tb/tb_ann_coef_loader.sv
// tb/tb_ann_coef_loader.sv - self-checking bench for ann_coef_loader
module tb_ann_coef_loader;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        request_coef;
    logic [1:0]  coef_select;
    logic        sram_read_en;
    logic [15:0] sram_addr;
    logic [15:0] sram_rdata;
    logic        sram_rvalid;
    logic        coef_wr_en;
    logic [10:0] coef_addr;
    logic [15:0] coef_data;
    logic [1:0]  coef_dest;
    logic        image_weights_loaded;
    logic        busy;

    always #5 clk = ~clk;

    ann_coef_loader dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .request_coef         (request_coef),
        .coef_select          (coef_select),
        .sram_read_en         (sram_read_en),
        .sram_addr            (sram_addr),
        .sram_rdata           (sram_rdata),
        .sram_rvalid          (sram_rvalid),
        .coef_wr_en           (coef_wr_en),
        .coef_addr            (coef_addr),
        .coef_data            (coef_data),
        .coef_dest            (coef_dest),
        .image_weights_loaded (image_weights_loaded),
        .busy                 (busy)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Block geometry taken straight from the layer sizes and base addresses.
    task automatic ref_block(input logic [1:0] sel, output int n, output logic [15:0] base);
        case (sel)
            2'b00:   begin n = 64 * 16; base = 16'h0040; end
            2'b01:   begin n = 16 * 8;  base = 16'h0440; end
            2'b10:   begin n = 8 * 10;  base = 16'h04C0; end
            default: begin n = 64;      base = 16'h0000; end
        endcase
    endtask

    // SRAM model: word at address a reads as a ^ key, returned lat cycles after the strobe.
    bit          mdl_en = 1'b1;
    int          lat    = 1;
    logic [15:0] key    = 16'h0000;
    int          cd     = 0;
    logic [15:0] addr_lat;
    int          overlap = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (mdl_en) begin
                sram_rvalid = 1'b0;
                if (!n_rst) begin
                    cd = 0;
                end else begin
                    if (cd > 0) begin
                        cd--;
                        if (cd == 0) begin
                            sram_rvalid = 1'b1;
                            sram_rdata  = addr_lat ^ key;
                        end
                    end
                    if (sram_read_en) begin
                        if (cd != 0) overlap++;
                        cd       = lat;
                        addr_lat = sram_addr;
                    end
                end
            end
        end
    end

    typedef struct {
        logic [10:0] a;
        logic [15:0] d;
        logic [1:0]  dest;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] rq[$];
    int          loaded_cnt = 0;
    time         load_time  = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (coef_wr_en) wq.push_back('{a: coef_addr, d: coef_data, dest: coef_dest});
            if (sram_read_en) rq.push_back(sram_addr);
            if (image_weights_loaded) begin
                if (loaded_cnt == 0) load_time = $time;
                loaded_cnt++;
            end
        end
    end

    task automatic clear_obs();
        wq.delete();
        rq.delete();
        loaded_cnt = 0;
        overlap    = 0;
    endtask

    task automatic run_load(input logic [1:0] sel, input int l, input bit rereq, input logic [1:0] rsel);
        int          n;
        logic [15:0] base;
        time         t0;
        int          bad_w;
        int          bad_r;
        ref_block(sel, n, base);
        lat = l;
        key = 16'($urandom);
        if (sel == 2'b11 && l == 1) key = 16'h0000;
        clear_obs();
        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = sel;
        t0 = $time;
        @(negedge clk);
        request_coef = 1'b0;
        coef_select  = 2'($urandom);
        for (int c = 0; c < 20000 && loaded_cnt == 0; c++) begin
            @(negedge clk);
            #1;
            if (rereq && c == 5) begin
                request_coef = 1'b1;
                coef_select  = rsel;
            end else begin
                request_coef = 1'b0;
            end
        end
        request_coef = 1'b0;
        check("loaded_seen", 64'(loaded_cnt != 0), 64'd1);
        repeat (6) @(negedge clk);
        #1;
        check("loaded_once", 64'(loaded_cnt), 64'd1);
        check("busy_after", 64'(busy), 64'd0);
        check("write_count", 64'(wq.size()), 64'(n));
        check("read_count", 64'(rq.size()), 64'(n));
        check("one_outstanding", 64'(overlap), 64'd0);
        check("dest_held", 64'(coef_dest), 64'(sel));
        check("load_latency", 64'((load_time - t0) / 10), 64'(n * (l + 2) + 1));
        bad_w = 0;
        bad_r = 0;
        for (int i = 0; i < n && i < wq.size(); i++) begin
            if (wq[i].a !== 11'(i) || wq[i].d !== ((base + 16'(i)) ^ key) || wq[i].dest !== sel) begin
                if (bad_w == 0)
                    $display("FAIL write_word[%0d]: got a=%0h d=%0h dest=%0h expected a=%0h d=%0h dest=%0h",
                             i, wq[i].a, wq[i].d, wq[i].dest, i, (base + 16'(i)) ^ key, sel);
                bad_w++;
            end
        end
        for (int i = 0; i < n && i < rq.size(); i++) begin
            if (rq[i] !== base + 16'(i)) bad_r++;
        end
        check("write_contents", 64'(bad_w), 64'd0);
        check("read_addresses", 64'(bad_r), 64'd0);
        if (rq.size() == n) check("final_sram_addr", 64'(rq[n-1]), 64'(base + 16'(n - 1)));
    endtask

    typedef struct {
        logic [1:0] sel;
        int         l;
        bit         rereq;
        logic [1:0] rsel;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{sel: 2'b11, l: 1, rereq: 1'b0, rsel: 2'b00};
        vecs[1] = '{sel: 2'b10, l: 4, rereq: 1'b0, rsel: 2'b00};
        vecs[2] = '{sel: 2'b00, l: 1, rereq: 1'b0, rsel: 2'b00};
        vecs[3] = '{sel: 2'b01, l: 2, rereq: 1'b1, rsel: 2'b10};

        n_rst        = 1'b0;
        request_coef = 1'b0;
        coef_select  = 2'b00;
        sram_rvalid  = 1'b0;
        sram_rdata   = 16'h0000;
        #1;
        check("reset_outputs", {15'd0, sram_read_en, sram_addr, coef_wr_en, coef_addr, coef_data,
                                coef_dest, image_weights_loaded, busy}, 64'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;

        for (int v = 0; v < 4; v++) run_load(vecs[v].sel, vecs[v].l, vecs[v].rereq, vecs[v].rsel);

        for (int r = 0; r < 4; r++) run_load(2'($urandom), int'($urandom_range(1, 4)), 1'b0, 2'b00);

        // Reset in the middle of a W2 load.
        lat = 1;
        key = 16'($urandom);
        clear_obs();
        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = 2'b01;
        @(negedge clk);
        request_coef = 1'b0;
        for (int c = 0; c < 2000 && wq.size() < 20; c++) begin
            @(negedge clk);
            #1;
        end
        check("reached_word20", 64'(wq.size() >= 20), 64'd1);
        n_rst = 1'b0;
        #1;
        check("midreset_outputs", {15'd0, sram_read_en, sram_addr, coef_wr_en, coef_addr, coef_data,
                                   coef_dest, image_weights_loaded, busy}, 64'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("no_pulse_after_abort", 64'(loaded_cnt), 64'd0);
        check("idle_after_abort", 64'(busy), 64'd0);
        run_load(2'b11, 1, 1'b0, 2'b00);

        // Spurious rvalid in IDLE and ISSUE.
        mdl_en = 1'b0;
        sram_rvalid = 1'b0;
        clear_obs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            sram_rvalid = 1'b1;
            sram_rdata  = 16'($urandom);
        end
        @(negedge clk);
        sram_rvalid = 1'b0;
        #1;
        check("idle_rvalid_busy", 64'(busy), 64'd0);
        check("idle_rvalid_writes", 64'(wq.size()), 64'd0);
        @(negedge clk);
        request_coef = 1'b1;
        coef_select  = 2'b11;
        @(negedge clk);
        request_coef = 1'b0;
        sram_rvalid  = 1'b1;
        sram_rdata   = 16'hDEAD;
        #1;
        check("issue_strobe", 64'(sram_read_en), 64'd1);
        @(negedge clk);
        sram_rvalid = 1'b0;
        #1;
        check("wait_no_strobe", 64'({busy, sram_read_en}), 64'b10);
        repeat (5) @(negedge clk);
        #1;
        check("issue_rvalid_writes", 64'(wq.size()), 64'd0);
        check("wait_holds_addr", 64'({busy, sram_addr}), {47'd0, 1'b1, 16'h0000});
        @(negedge clk);
        sram_rvalid = 1'b1;
        sram_rdata  = 16'h1234;
        @(negedge clk);
        sram_rvalid = 1'b0;
        #1;
        check("manual_write", 64'({coef_wr_en, coef_addr, coef_data}), {36'd0, 1'b1, 11'd0, 16'h1234});
        n_rst = 1'b0;
        @(negedge clk);
        n_rst  = 1'b1;
        mdl_en = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ann_coef_loader.md
Name: ann_coef_loader

Overview:
Responder side of the ANN coefficient request handshake. On a one-cycle request_coef pulse it latches coef_select, reads the selected block (input image or one layer's weights) word by word from SRAM, and writes each word into the ANN's coefficient/input buffer. When the block is complete it pulses image_weights_loaded for one cycle. It sits between the SRAM interface and the ANN datapath, alongside the ANN controller that issues the requests.

Parameters:
IMAGE_SIZE, 64, pixel words in one image (8x8 grayscale)
FIRST_LAYER, 16, layer-1 node count
SECOND_LAYER, 8, layer-2 node count
THIRD_LAYER, 10, output node count
DATA_WIDTH, 16, SRAM and coefficient word width
ADDR_WIDTH, 16, SRAM word-address width
IMAGE_BASE, 16'h0000, SRAM base address of the image
W1_BASE, 16'h0040, base address of the layer-1 weights (IMAGE_SIZE*FIRST_LAYER words)
W2_BASE, 16'h0440, base address of the layer-2 weights (FIRST_LAYER*SECOND_LAYER words)
W3_BASE, 16'h04C0, base address of the layer-3 weights (SECOND_LAYER*THIRD_LAYER words)

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
request_coef  in  1  one-cycle load request
coef_select  in  2  block select: 00=W1, 01=W2, 10=W3, 11=image; sampled only when a request is accepted
sram_read_en  out  1  one-cycle SRAM read strobe
sram_addr  out  ADDR_WIDTH  SRAM word address
sram_rdata  in  DATA_WIDTH  SRAM read data, valid while sram_rvalid=1
sram_rvalid  in  1  read data valid; arrives at least 1 cycle after sram_read_en
coef_wr_en  out  1  write strobe into the ANN buffer
coef_addr  out  11  buffer index, 0..count-1
coef_data  out  DATA_WIDTH  buffer write data
coef_dest  out  2  latched coef_select, qualifies coef_wr_en
image_weights_loaded  out  1  one-cycle pulse when the block is complete
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, asynchronous: state=IDLE. All outputs are 0, including coef_dest, coef_addr and coef_data. The word counter and latched select are cleared. Reset asserted mid-transfer aborts the transfer and produces no completion pulse.
- Word count per select: 00 -> IMAGE_SIZE*FIRST_LAYER (1024); 01 -> FIRST_LAYER*SECOND_LAYER (128); 10 -> SECOND_LAYER*THIRD_LAYER (80); 11 -> IMAGE_SIZE (64). Base address comes from the matching *_BASE parameter.
- Counter is 11 bits. sram_addr = base + counter, truncated to ADDR_WIDTH.
- State machine:
  - IDLE: when request_coef=1, latch coef_select into coef_dest, clear counter, go to ISSUE.
  - ISSUE: sram_read_en=1 and sram_addr driven for exactly 1 cycle; go to WAIT_DATA.
  - WAIT_DATA: hold sram_addr. When sram_rvalid=1, register sram_rdata and go to WRITE. Stays in WAIT_DATA indefinitely without rvalid; there is no timeout.
  - WRITE: coef_wr_en=1 for 1 cycle, with coef_data = registered word and coef_addr = counter. If counter == count-1, go to DONE; otherwise increment counter and go to ISSUE.
  - DONE: image_weights_loaded=1 for 1 cycle; go to IDLE.
- sram_rvalid is ignored in every state except WAIT_DATA.
- request_coef is ignored when not in IDLE; the latched select is not disturbed.
- Latency: request seen at edge T -> first sram_read_en during cycle T+1. With 1-cycle SRAM latency each word takes 3 cycles. image_weights_loaded rises 3*N+1 cycles after the request edge (N = word count).
- A request in the same cycle as the return to IDLE from DONE is not possible; a request arriving in the cycle after DONE is accepted normally.
- Outputs are registered or decoded from the state register only, so the strobes carry no combinational path from inputs.

Decomposition:
- Shared package ann_pkg holds:
  - the coef_select encodings (SEL_W1=00, SEL_W2=01, SEL_W3=10, SEL_IMAGE=11);
  - the layer-size constants;
  - the loader state enum {IDLE, ISSUE, WAIT_DATA, WRITE, DONE}.
- The ANN controller imports the same select encodings from ann_pkg.
- One sub-module, ann_block_lut: combinational map from select to {base address, word count}.

Test Plan:
- Image load: request_coef with select=11 against a 1-cycle-latency SRAM model where mem[a]=a -> 64 writes, coef_addr 0..63 with data 0x0000..0x003F, coef_dest=11; loaded pulse exactly once, 193 cycles after the request.
- W3 load with rvalid delayed 4 cycles -> 80 writes, sram_addr 0x04C0..0x050F in order, one read outstanding at a time; loaded pulse once, then busy=0.
- W1 full-size load -> 1024 writes with counter reaching 1023 and no wrap; final sram_addr 0x043F; no extra write after DONE.
- Request with select=01 pulsed again while busy with select=10 -> ignored; coef_dest stays 01; exactly 128 writes.
- n_rst asserted at word 20 of a W2 load -> outputs 0 immediately and no loaded pulse. A new image request after reset restarts at coef_addr 0 and address 0x0000.
- Spurious sram_rvalid in IDLE and ISSUE -> no coef_wr_en and no state change.
